cdp_rd_responder: RTL and testbench

CDP_RD_RESPONDER -- requirements
Module: cdp_rd_responder

---
 rtl/cdp_rd_responder.sv | 218 +++++++++++++++++++++
 tb/tb_cdp_rd_responder.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdp_rd_responder.sv
// cdp_rd_responder: read-response generator for the CDP memory read port.
// Requests (byte address + atom count) are queued in a small FIFO. A
// two-state engine turns each request into 64B response beats: each beat
// carries one or two 32B atoms, each half filled with a pattern derived
// from the atom index. Beats are metered by a latency-FIFO credit counter
// that the requester replenishes.
//
// state | meaning
// IDLE  | no burst in flight; waits for a queued request
// BEAT  | burst in flight; presents beats while credits are available

module cdp_rd_responder #(
    parameter int REQ_DEPTH   = 4,
    parameter int LAT_CREDITS = 16
) (
    input  logic         nvdla_core_clk,
    input  logic         nvdla_core_rst,
    input  logic         cdp2mcif_rd_req_valid,
    output logic         cdp2mcif_rd_req_ready,
    input  logic [78:0]  cdp2mcif_rd_req_pd,
    output logic         mcif2cdp_rd_rsp_valid,
    input  logic         mcif2cdp_rd_rsp_ready,
    output logic [513:0] mcif2cdp_rd_rsp_pd,
    input  logic         cdp2mcif_rd_cdt_lat_fifo_pop,
    output logic         rsp_idle,
    output logic         cdt_overflow
);

    localparam int PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(REQ_DEPTH);
    localparam logic [7:0]       CREDIT_MAX = 8'(LAT_CREDITS);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BEAT = 1'b1
    } state_t;

    // request FIFO
    logic [78:0]      fifo_mem [REQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_push;
    logic             fifo_pop;
    logic [78:0]      head_pd;
    logic             addr_lsb_unused;

    // engine
    state_t      state_q;
    state_t      state_d;
    logic [58:0] atom_ptr;
    logic [15:0] remain;
    logic        start_half;

    // current beat
    logic [1:0]  beat_mask;
    logic [1:0]  beat_consume;
    logic        beat_last;
    logic        beat_valid;
    logic [31:0] lo_atom;
    logic [31:0] hi_atom;
    logic        rsp_hs;

    // credits
    logic [7:0]  credit_cnt;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == DEPTH_C);
    assign cdp2mcif_rd_req_ready = !fifo_full;
    assign fifo_push  = cdp2mcif_rd_req_valid && !fifo_full;
    assign head_pd    = fifo_mem[rd_ptr];
    // Sub-atom address bits carry no information for a 32B-granular read.
    assign addr_lsb_unused = ^head_pd[4:0];

    assign beat_valid = (state_q == S_BEAT) && (credit_cnt != 8'd0);
    assign rsp_hs     = beat_valid && mcif2cdp_rd_rsp_ready;

    // Request storage; payload needs no reset since occupancy is tracked separately.
    always_ff @(posedge nvdla_core_clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= cdp2mcif_rd_req_pd;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Beat shaping: an odd start atom sends only the upper half; otherwise
    // send a full pair unless just one atom is left.
    always_comb begin
        beat_mask    = 2'b01;
        beat_consume = 2'd1;
        if (start_half) begin
            beat_mask    = 2'b10;
            beat_consume = 2'd1;
        end else if (remain >= 16'd2) begin
            beat_mask    = 2'b11;
            beat_consume = 2'd2;
        end
        beat_last = (remain == {14'd0, beat_consume});
        lo_atom   = atom_ptr[31:0];
        hi_atom   = start_half ? atom_ptr[31:0] : (atom_ptr[31:0] + 32'd1);
    end

    // FSM state register.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave IDLE on any queued request, return only when the
    // last beat completes with nothing waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_BEAT;
                end
            end
            S_BEAT: begin
                if (rsp_hs && beat_last && fifo_empty) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: response beat, FIFO pop (also loads the engine) and idle.
    always_comb begin
        mcif2cdp_rd_rsp_valid = beat_valid;
        mcif2cdp_rd_rsp_pd    = '0;
        fifo_pop              = 1'b0;
        rsp_idle              = 1'b0;
        case (state_q)
            S_IDLE: begin
                fifo_pop = !fifo_empty;
                rsp_idle = fifo_empty;
            end
            S_BEAT: begin
                mcif2cdp_rd_rsp_pd[513:512] = beat_mask;
                if (beat_mask[0]) begin
                    mcif2cdp_rd_rsp_pd[255:0] = {8{lo_atom}};
                end
                if (beat_mask[1]) begin
                    mcif2cdp_rd_rsp_pd[511:256] = {8{hi_atom}};
                end
                fifo_pop = rsp_hs && beat_last && !fifo_empty;
            end
            default: begin
                rsp_idle = 1'b0;
            end
        endcase
    end

    // Burst context: load from the FIFO head, or advance past the sent atoms.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            atom_ptr   <= '0;
            remain     <= '0;
            start_half <= 1'b0;
        end else if (fifo_pop) begin
            atom_ptr   <= head_pd[63:5];
            remain     <= {1'b0, head_pd[78:64]} + 16'd1;
            start_half <= head_pd[5];
        end else if (rsp_hs) begin
            atom_ptr   <= atom_ptr + {57'd0, beat_consume};
            remain     <= remain - {14'd0, beat_consume};
            start_half <= 1'b0;
        end
    end

    // Credit accounting; a return with credits already full is dropped and flagged.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            credit_cnt   <= CREDIT_MAX;
            cdt_overflow <= 1'b0;
        end else begin
            case ({rsp_hs, cdp2mcif_rd_cdt_lat_fifo_pop})
                2'b10: credit_cnt <= credit_cnt - 8'd1;
                2'b01: begin
                    if (credit_cnt == CREDIT_MAX) begin
                        cdt_overflow <= 1'b1;
                    end else begin
                        credit_cnt <= credit_cnt + 8'd1;
                    end
                end
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_cdp_rd_responder.sv
// Bench for cdp_rd_responder: a queue-based reference model compared every
// cycle, directed scenarios with literal expectations, and random traffic.
`timescale 1ns/1ps
module tb_cdp_rd_responder;

    localparam int DEPTH = 4;
    localparam int LAT   = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [78:0]  req_pd = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [513:0] rsp_pd;
    logic         lat_pop = 1'b0;
    logic         idle;
    logic         ovf;

    logic         req_valid2 = 1'b0;
    logic         req_ready2;
    logic [78:0]  req_pd2 = '0;
    logic         rsp_valid2;
    logic         rsp_ready2 = 1'b0;
    logic [513:0] rsp_pd2;
    logic         lat_pop2 = 1'b0;
    logic         idle2;
    logic         ovf2;

    int n_checks = 0;
    int n_fail   = 0;

    cdp_rd_responder #(.REQ_DEPTH(DEPTH), .LAT_CREDITS(LAT)) dut (
        .nvdla_core_clk               (clk),
        .nvdla_core_rst               (rst),
        .cdp2mcif_rd_req_valid        (req_valid),
        .cdp2mcif_rd_req_ready        (req_ready),
        .cdp2mcif_rd_req_pd           (req_pd),
        .mcif2cdp_rd_rsp_valid        (rsp_valid),
        .mcif2cdp_rd_rsp_ready        (rsp_ready),
        .mcif2cdp_rd_rsp_pd           (rsp_pd),
        .cdp2mcif_rd_cdt_lat_fifo_pop (lat_pop),
        .rsp_idle                     (idle),
        .cdt_overflow                 (ovf)
    );

    cdp_rd_responder #(.REQ_DEPTH(4), .LAT_CREDITS(2)) dut2 (
        .nvdla_core_clk               (clk),
        .nvdla_core_rst               (rst),
        .cdp2mcif_rd_req_valid        (req_valid2),
        .cdp2mcif_rd_req_ready        (req_ready2),
        .cdp2mcif_rd_req_pd           (req_pd2),
        .mcif2cdp_rd_rsp_valid        (rsp_valid2),
        .mcif2cdp_rd_rsp_ready        (rsp_ready2),
        .mcif2cdp_rd_rsp_pd           (rsp_pd2),
        .cdp2mcif_rd_cdt_lat_fifo_pop (lat_pop2),
        .rsp_idle                     (idle2),
        .cdt_overflow                 (ovf2)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_pd(input string name, input logic [513:0] act, input logic [513:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Burst = next atom index + atoms left. A beat covers the atoms from the
    // next index up to the end of its 64B pair, capped by what is left.
    logic [78:0] mq[$];
    bit          m_act  = 1'b0;
    logic [58:0] m_ptr  = '0;
    int          m_left = 0;
    int          m_cred = LAT;
    bit          m_ovf  = 1'b0;

    function automatic int beat_atoms(input logic [58:0] p, input int left);
        int n;
        n = p[0] ? 1 : 2;
        if (n > left) n = left;
        return n;
    endfunction

    function automatic logic [513:0] beat_pd(input logic [58:0] p, input int left);
        logic [513:0] r;
        logic [58:0]  a;
        r = '0;
        for (int k = 0; k < beat_atoms(p, left); k++) begin
            a = p + 59'(k);
            if (a[0]) begin
                r[511:256] = {8{a[31:0]}};
                r[513]     = 1'b1;
            end else begin
                r[255:0]   = {8{a[31:0]}};
                r[512]     = 1'b1;
            end
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_act  = 1'b0;
            m_left = 0;
            m_cred = LAT;
            m_ovf  = 1'b0;
        end else begin : upd
            bit          hs;
            bit          push;
            int          qsz;
            int          n;
            logic [78:0] h;
            qsz  = mq.size();
            hs   = m_act && (m_cred != 0) && rsp_ready;
            push = req_valid && (qsz < DEPTH);
            if (hs) begin
                n      = beat_atoms(m_ptr, m_left);
                m_ptr  = m_ptr + 59'(n);
                m_left = m_left - n;
                if (m_left == 0) m_act = 1'b0;
            end
            if (hs && !lat_pop) begin
                m_cred--;
            end else if (lat_pop && !hs) begin
                if (m_cred == LAT) m_ovf = 1'b1;
                else m_cred++;
            end
            if (!m_act && qsz > 0) begin
                h      = mq.pop_front();
                m_act  = 1'b1;
                m_ptr  = h[63:5];
                m_left = int'(h[78:64]) + 1;
            end
            if (push) mq.push_back(req_pd);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check1("rst_req_ready", req_ready, 1'b1);
            check1("rst_rsp_valid", rsp_valid, 1'b0);
            check1("rst_rsp_idle", idle, 1'b1);
            check1("rst_overflow", ovf, 1'b0);
            check_pd("rst_rsp_pd", rsp_pd, '0);
        end else begin : cmp
            bit ev;
            ev = m_act && (m_cred != 0);
            check1("req_ready", req_ready, mq.size() < DEPTH);
            check1("rsp_valid", rsp_valid, ev);
            check1("rsp_idle", idle, !m_act && (mq.size() == 0));
            check1("cdt_overflow", ovf, m_ovf);
            if (ev) check_pd("rsp_pd", rsp_pd, beat_pd(m_ptr, m_left));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid  = 1'b0;
        rsp_ready  = 1'b0;
        lat_pop    = 1'b0;
        req_valid2 = 1'b0;
        rsp_ready2 = 1'b0;
        lat_pop2   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        cyc();
    endtask

    task automatic push_req(input logic [14:0] size, input logic [63:0] addr);
        req_valid = 1'b1;
        req_pd    = {size, addr};
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int max);
        int k;
        k = 0;
        while (!rsp_valid && k < max) begin
            cyc();
            k++;
        end
        check1(name, rsp_valid, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        int acc;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        cyc();

        // two-credit instance: credits gate the beat count
        req_valid2 = 1'b1;
        req_pd2    = {15'd7, 64'h0};
        rsp_ready2 = 1'b1;
        cyc();
        req_valid2 = 1'b0;
        beats = 0;
        repeat (20) begin
            if (rsp_valid2) beats++;
            cyc();
        end
        check_int("lat2_beats_no_pop", beats, 2);
        check1("lat2_valid_low", rsp_valid2, 1'b0);
        lat_pop2 = 1'b1;
        cyc();
        lat_pop2 = 1'b0;
        beats = 0;
        repeat (10) begin
            if (rsp_valid2) beats++;
            cyc();
        end
        check_int("lat2_beats_one_pop", beats, 1);

        // single atom, even address
        do_reset();
        rsp_ready = 1'b1;
        push_req(15'd0, 64'h1000);
        wait_valid("single_wait", 5);
        check_pd("single_pd", rsp_pd, {2'b01, 256'h0, {8{32'h80}}});
        cyc();
        check1("single_valid_low", rsp_valid, 1'b0);
        check1("single_idle", idle, 1'b1);

        // odd start, three atoms
        push_req(15'd2, 64'h1020);
        wait_valid("odd_wait", 5);
        check_pd("odd_beat1", rsp_pd, {2'b10, {8{32'h81}}, 256'h0});
        cyc();
        check_pd("odd_beat2", rsp_pd, {2'b11, {8{32'h83}}, {8{32'h82}}});
        cyc();
        check1("odd_idle", idle, 1'b1);

        // atom pointer wrap at 2^59
        push_req(15'd2, 64'hFFFF_FFFF_FFFF_FFE0);
        wait_valid("wrap_wait", 5);
        check_pd("wrap_beat1", rsp_pd, {2'b10, {8{32'hFFFF_FFFF}}, 256'h0});
        cyc();
        check_pd("wrap_beat2", rsp_pd, {2'b11, {8{32'h1}}, 256'h0});
        cyc();

        // back-to-back queueing with the sink stalled
        do_reset();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_pd    = {15'd1, 64'(i) * 64'h40};
            if (req_ready) acc++;
            if (i == 5) check1("b2b_ready_6th", req_ready, 1'b0);
            cyc();
        end
        req_valid = 1'b0;
        check_int("b2b_accepted", acc, 5);
        check1("b2b_engine_loaded", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check1("b2b_consecutive", rsp_valid, 1'b1);
            check_pd("b2b_pd", rsp_pd, {2'b11, {8{32'(2 * k + 1)}}, {8{32'(2 * k)}}});
            cyc();
        end
        check1("b2b_done", rsp_valid, 1'b0);

        // stall mid-burst: beat must hold
        do_reset();
        rsp_ready = 1'b1;
        push_req(15'd7, 64'h2000);
        wait_valid("stall_wait", 5);
        cyc();
        rsp_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            lat_pop = (k == 3);
            check1("stall_valid", rsp_valid, 1'b1);
            check_pd("stall_pd", rsp_pd, {2'b11, {8{32'h103}}, {8{32'h102}}});
            cyc();
        end
        lat_pop   = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 20 && !idle; k++) cyc();
        check1("stall_drained", idle, 1'b1);

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req_valid = ($urandom_range(0, 99) < 40);
            req_pd    = {15'($urandom_range(0, ($urandom_range(0, 9) == 0) ? 40 : 5)),
                         32'($urandom), 32'($urandom)};
            rsp_ready = ($urandom_range(0, 99) < 70);
            lat_pop   = ($urandom_range(0, 99) < 30);
            cyc();
        end

        // maximum size request, odd start
        do_reset();
        rsp_ready = 1'b1;
        push_req(15'h7FFF, 64'h0000_0123_4567_89A0);
        beats = 0;
        for (int c = 0; c < 17000 && !idle; c++) begin
            lat_pop = rsp_valid;
            if (rsp_valid) beats++;
            cyc();
        end
        lat_pop = 1'b0;
        check_int("max_size_beats", beats, 16385);
        check1("max_size_idle", idle, 1'b1);

        // reset mid-burst, queued request dropped, then credit overflow
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_pd    = {15'd7, 64'h0};
        cyc();
        req_pd    = {15'd3, 64'h400};
        cyc();
        req_valid = 1'b0;
        check1("abort_beat1_valid", rsp_valid, 1'b1);
        cyc();
        rsp_ready = 1'b0;
        check1("abort_beat2_valid", rsp_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check1("abort_valid", rsp_valid, 1'b0);
        check_pd("abort_pd", rsp_pd, '0);
        check1("abort_ready", req_ready, 1'b1);
        check1("abort_idle", idle, 1'b1);
        check_int("abort_credits", int'(dut.credit_cnt), LAT);
        @(posedge clk);
        #2 rst = 1'b0;
        cyc();
        repeat (3) cyc();
        check1("abort_queue_dropped", idle, 1'b1);
        check1("ovf_before_pop", ovf, 1'b0);
        lat_pop = 1'b1;
        cyc();
        lat_pop = 1'b0;
        check1("ovf_set", ovf, 1'b1);
        check_int("ovf_credits_unchanged", int'(dut.credit_cnt), LAT);
        rsp_ready = 1'b1;
        push_req(15'd1, 64'h40);
        repeat (5) cyc();
        check1("ovf_sticky", ovf, 1'b1);

        idle_inputs();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
